// File: rtl/segment_rasterizer.sv
// Command FIFO plus raster FSM that turns clear/rectangle commands into one pixel write per cycle.
// Optional build macro SEGRAST_CLIP_EN clamps rectangles to the screen instead of masking writes.
module segment_rasterizer #(
   parameter int unsigned N          = 11,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned SCREEN_H   = 480,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] cmd_x0,
   input  logic [N-1:0] cmd_y0,
   input  logic [N-1:0] cmd_x1,
   input  logic [N-1:0] cmd_y1,
   input  logic         cmd_clear,
   input  logic         cmd_wr,
   output logic         cmd_ready,
   output logic [N-1:0] pix_x,
   output logic [N-1:0] pix_y,
   output logic         pix_color,
   output logic         pix_we,
   output logic         busy,
   output logic         clear_done,
   output logic         overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned EW = 4 * N + 1;
   localparam logic [N-1:0] XLAST = N'(SCREEN_W - 1);
   localparam logic [N-1:0] YLAST = N'(SCREEN_H - 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StLoad, StDraw, StClear} state_e;

   state_e        state_q, state_d;
   logic [EW-1:0] fifo_q [FIFO_DEPTH];
   logic [EW-1:0] fifo_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] cmd_q, cmd_d;
   logic [N-1:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   logic [N-1:0]  cx_q, cx_d, cy_q, cy_d;
   logic          clear_done_q, clear_done_d, overflow_q, overflow_d;

   logic          push, pop, x_end, y_end, ld_clear;
   logic [N-1:0]  ld_x0, ld_y0, ld_x1, ld_y1, ld_xmin, ld_xmax, ld_ymin, ld_ymax;

   assign cmd_ready = !reset && (count_q != FULL);
   assign push      = cmd_wr && cmd_ready;
   assign pop       = (state_q == StIdle) && (count_q != '0);
   assign x_end     = (cx_q == xmax_q);
   assign y_end     = (cy_q == ymax_q);

   assign ld_clear = cmd_q[EW-1];
   assign ld_x0    = cmd_q[4*N-1:3*N];
   assign ld_y0    = cmd_q[3*N-1:2*N];
   assign ld_x1    = cmd_q[2*N-1:N];
   assign ld_y1    = cmd_q[N-1:0];

   always_comb begin
      ld_xmin = (ld_x0 < ld_x1) ? ld_x0 : ld_x1;
      ld_xmax = (ld_x0 < ld_x1) ? ld_x1 : ld_x0;
      ld_ymin = (ld_y0 < ld_y1) ? ld_y0 : ld_y1;
      ld_ymax = (ld_y0 < ld_y1) ? ld_y1 : ld_y0;
`ifdef SEGRAST_CLIP_EN
      if (ld_xmax > XLAST) ld_xmax = XLAST;
      if (ld_ymax > YLAST) ld_ymax = YLAST;
`endif
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (count_q != '0) state_d = StLoad;
         StLoad: begin
            if (ld_clear)                                  state_d = StClear;
            else if (ld_xmin > XLAST || ld_ymin > YLAST)   state_d = StIdle;
            else                                           state_d = StDraw;
         end
         StDraw, StClear: if (x_end && y_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      pix_x      = cx_q;
      pix_y      = cy_q;
      pix_color  = (state_q == StDraw);
      busy       = (state_q != StIdle) || (count_q != '0);
      clear_done = clear_done_q;
      overflow   = overflow_q;
      pix_we     = 1'b0;
      if (state_q == StClear) pix_we = 1'b1;
`ifdef SEGRAST_CLIP_EN
      if (state_q == StDraw) pix_we = 1'b1;
`else
      if (state_q == StDraw) pix_we = (cx_q <= XLAST) && (cy_q <= YLAST);
`endif
   end

   // FIFO and raster datapath
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cmd_d    = cmd_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         cmd_d    = fifo_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      overflow_d = overflow_q || (cmd_wr && !cmd_ready);
   end

   // Clear reuses the rectangle scan with the full screen as bounds.
   always_comb begin
      xmin_d       = xmin_q;
      xmax_d       = xmax_q;
      ymin_d       = ymin_q;
      ymax_d       = ymax_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      clear_done_d = (state_q == StClear) && x_end && y_end;
      case (state_q)
         StLoad: begin
            if (ld_clear) begin
               xmin_d = '0;
               xmax_d = XLAST;
               ymin_d = '0;
               ymax_d = YLAST;
               cx_d   = '0;
               cy_d   = '0;
            end else begin
               xmin_d = ld_xmin;
               xmax_d = ld_xmax;
               ymin_d = ld_ymin;
               ymax_d = ld_ymax;
               cx_d   = ld_xmin;
               cy_d   = ld_ymin;
            end
         end
         StDraw, StClear: begin
            if (!x_end) begin
               cx_d = cx_q + 1'b1;
            end else if (!y_end) begin
               cx_d = xmin_q;
               cy_d = cy_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cmd_q        <= '0;
         xmin_q       <= '0;
         xmax_q       <= '0;
         ymin_q       <= '0;
         ymax_q       <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         clear_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cmd_q        <= cmd_d;
         xmin_q       <= xmin_d;
         xmax_q       <= xmax_d;
         ymin_q       <= ymin_d;
         ymax_q       <= ymax_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         clear_done_q <= clear_done_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset; the pointers define validity.
   always_ff @(posedge clock) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_segment_rasterizer.sv
// Directed bench for segment_rasterizer on a reduced 64x48 screen so a full clear stays short.
module tb_segment_rasterizer;
   localparam int N = 11;
   localparam int W = 64;
   localparam int H = 48;
`ifdef SEGRAST_CLIP_EN
   localparam int EXP_D = 16;
`else
   localparam int EXP_D = 77;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic         cmd_clear = 1'b0, cmd_wr = 1'b0;
   logic         cmd_ready, pix_color, pix_we, busy, clear_done, overflow;
   logic [N-1:0] pix_x, pix_y;

   int total = 0;
   int bad = 0;

   int   qx[$];
   int   qy[$];
   logic qc[$];
   int   cd_pulses = 0;
   int   cd_idx = -1;
   logic cd_we = 1'b0;

   segment_rasterizer #(.N(N), .SCREEN_W(W), .SCREEN_H(H), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
      .cmd_clear(cmd_clear), .cmd_wr(cmd_wr), .cmd_ready(cmd_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
      .busy(busy), .clear_done(clear_done), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Pixel recorder: frame-buffer view of every write strobe.
   always @(negedge clock) begin
      if (pix_we) begin
         qx.push_back(int'(pix_x));
         qy.push_back(int'(pix_y));
         qc.push_back(pix_color);
      end
      if (clear_done) begin
         cd_pulses++;
         cd_idx = qx.size();
         cd_we  = pix_we;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic clr, input int x0, input int y0, input int x1, input int y1);
      cmd_clear = clr;
      cmd_x0 = N'(x0);
      cmd_y0 = N'(y0);
      cmd_x1 = N'(x1);
      cmd_y1 = N'(y1);
      cmd_wr = 1'b1;
      tick();
      cmd_wr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int bound, output int n);
      n = 0;
      while (busy && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic clear_log();
      qx.delete();
      qy.delete();
      qc.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
      total++;
      if ({pix_we, pix_color, busy, clear_done, overflow} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got we=%b col=%b busy=%b cd=%b ovf=%b want all 0",
                  pix_we, pix_color, busy, clear_done, overflow);
      end
      total++;
      if (pix_x !== '0 || pix_y !== '0) begin
         bad++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
      end
      reset = 1'b0;
      tick();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_vline();
      push(1'b0, 10, 20, 10, 22);
      tick();
      total++;
      if (pix_we !== 1'b0) begin bad++; $display("FAIL vline_load_we: got %b want 0", pix_we); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({pix_we, pix_color, pix_x, pix_y} !== {1'b1, 1'b1, N'(10), N'(20 + i)}) begin
            bad++;
            $display("FAIL vline_pix%0d: got we=%b col=%b (%0d,%0d) want we=1 col=1 (10,%0d)",
                     i, pix_we, pix_color, pix_x, pix_y, 20 + i);
         end
      end
      tick();
      total++;
      if (pix_we !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL vline_end: got we=%b busy=%b want 0 0", pix_we, busy);
      end
   endtask

   task automatic test_swapped();
      push(1'b0, 12, 5, 10, 4);
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if ({pix_we, pix_color, pix_x, pix_y} !== {1'b1, 1'b1, N'(10 + i % 3), N'(4 + i / 3)}) begin
            bad++;
            $display("FAIL swap_pix%0d: got we=%b col=%b (%0d,%0d) want we=1 col=1 (%0d,%0d)",
                     i, pix_we, pix_color, pix_x, pix_y, 10 + i % 3, 4 + i / 3);
         end
      end
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL swap_busy: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic exp_we [6];
      int   exp_x [6];
      int   exp_y [6];
      exp_we = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_x  = '{1, 2, 0, 0, 5, 0};
      exp_y  = '{1, 1, 0, 0, 5, 0};
      push(1'b0, 1, 1, 2, 1);
      push(1'b0, 5, 5, 5, 5);
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (pix_we !== exp_we[i]) begin
            bad++; $display("FAIL b2b_we%0d: got %b want %b", i, pix_we, exp_we[i]);
         end
         if (exp_we[i]) begin
            total++;
            if (pix_x !== N'(exp_x[i]) || pix_y !== N'(exp_y[i])) begin
               bad++;
               $display("FAIL b2b_xy%0d: got (%0d,%0d) want (%0d,%0d)",
                        i, pix_x, pix_y, exp_x[i], exp_y[i]);
            end
         end
      end
   endtask

   task automatic test_clear_overflow();
      int n;
      int errs;
      clear_log();
      cd_pulses = 0;
      push(1'b1, 0, 0, 0, 0);
      repeat (5) tick();
      for (int k = 1; k <= 4; k++) push(1'b0, k, k, k, k);
      total++;
      if (cmd_ready !== 1'b0 || overflow !== 1'b0) begin
         bad++; $display("FAIL full_ready: got ready=%b ovf=%b want 0 0", cmd_ready, overflow);
      end
      push(1'b0, 9, 9, 9, 9);
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", overflow); end
      wait_idle(5000, n);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL clear_timeout: busy=%b after %0d cycles", busy, n); end
      total++;
      if (cd_pulses !== 1 || cd_idx !== W * H || cd_we !== 1'b0) begin
         bad++;
         $display("FAIL clear_done: got pulses=%0d at_pixel=%0d we=%b want 1 %0d 0",
                  cd_pulses, cd_idx, cd_we, W * H);
      end
      total++;
      if (qx.size() !== W * H + 4) begin
         bad++; $display("FAIL clear_count: got %0d writes want %0d", qx.size(), W * H + 4);
      end
      errs = 0;
      for (int i = 0; i < W * H && i < qx.size(); i++)
         if (qx[i] != i % W || qy[i] != i / W || qc[i] !== 1'b0) errs++;
      total++;
      if (errs !== 0) begin bad++; $display("FAIL clear_scan: got %0d bad pixels want 0", errs); end
      if (qx.size() >= W * H) begin
         total++;
         if (qx[W * H - 1] != W - 1 || qy[W * H - 1] != H - 1) begin
            bad++;
            $display("FAIL clear_last: got (%0d,%0d) want (%0d,%0d)",
                     qx[W * H - 1], qy[W * H - 1], W - 1, H - 1);
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (W * H + k < qx.size()) begin
            total++;
            if (qx[W * H + k] != k + 1 || qy[W * H + k] != k + 1 || qc[W * H + k] !== 1'b1) begin
               bad++;
               $display("FAIL queued_cmd%0d: got (%0d,%0d) col=%b want (%0d,%0d) col=1",
                        k, qx[W * H + k], qy[W * H + k], qc[W * H + k], k + 1, k + 1);
            end
         end
      end
      tick();
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_offscreen();
      int n;
      do_reset();
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_reset: got %b want 0", overflow); end
      clear_log();
      push(1'b0, 60, 44, 70, 50);
      wait_idle(500, n);
      total++;
      if (n - 2 !== EXP_D) begin bad++; $display("FAIL edge_draw_cycles: got %0d want %0d", n - 2, EXP_D); end
      total++;
      if (qx.size() !== 16) begin bad++; $display("FAIL edge_writes: got %0d want 16", qx.size()); end
      if (qx.size() == 16) begin
         total++;
         if (qx[0] != 60 || qy[0] != 44 || qx[15] != 63 || qy[15] != 47) begin
            bad++;
            $display("FAIL edge_corners: got (%0d,%0d)..(%0d,%0d) want (60,44)..(63,47)",
                     qx[0], qy[0], qx[15], qy[15]);
         end
      end
      clear_log();
      push(1'b0, 70, 10, 80, 20);
      wait_idle(100, n);
      total++;
      if (n !== 2 || qx.size() !== 0) begin
         bad++; $display("FAIL offscreen_reject: got cycles=%0d writes=%0d want 2 0", n, qx.size());
      end
   endtask

   task automatic test_reset_mid_draw();
      push(1'b0, 0, 0, 9, 9);
      push(1'b0, 20, 20, 20, 20);
      repeat (10) tick();
      total++;
      if (pix_we !== 1'b1) begin bad++; $display("FAIL mid_draw_active: got %b want 1", pix_we); end
      reset = 1'b1;
      tick();
      total++;
      if (pix_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got we=%b busy=%b ready=%b want 0 0 0", pix_we, busy, cmd_ready);
      end
      reset = 1'b0;
      clear_log();
      repeat (30) tick();
      total++;
      if (qx.size() !== 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL post_abort: got writes=%0d busy=%b ready=%b want 0 0 1",
                  qx.size(), busy, cmd_ready);
      end
   endtask

   initial begin
      test_reset();
      test_vline();
      test_swapped();
      test_back_to_back();
      test_clear_overflow();
      test_offscreen();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/segment_rasterizer.md
# segment_rasterizer

Consumer end of the segment command stream produced by the game's buffer controller. Accepts rectangle/line commands (x0, y0, x1, y1) and clear-screen commands, queues them in a small FIFO, and rasterizes each into single-pixel write strobes for the frame buffer. Clear commands paint the whole screen to background; draw commands fill an axis-aligned inclusive rectangle with foreground. Degenerate rectangles (x0==x1 or y0==y1) are pipe and bird lines.

## Interface
- N, 11, coordinate width (unsigned)
- SCREEN_W, 640, visible columns
- SCREEN_H, 480, visible rows
- FIFO_DEPTH, 4, command queue entries (power of two, ≥2)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  N each  rectangle corners, any order
- cmd_clear  in  1  1 = clear command (coordinates ignored)
- cmd_wr  in  1  command strobe; accepted on edge where cmd_wr && cmd_ready
- cmd_ready  out  1  FIFO not full; 0 during reset
- pix_x, pix_y  out  N each  pixel address
- pix_color  out  1  1 = foreground, 0 = background
- pix_we  out  1  pixel write strobe, one pixel per cycle
- busy  out  1  FSM not IDLE or FIFO non-empty
- clear_done  out  1  one-cycle pulse after last clear pixel
- overflow  out  1  sticky: cmd_wr seen while cmd_ready=0; cleared only by reset

## Operation
- FIFO entry = {clear, x0, y0, x1, y1}. Push when cmd_wr && cmd_ready; pop by FSM. Push and pop in same cycle allowed when not full. cmd_wr while full: command dropped, overflow set.
- FSM states IDLE, LOAD, DRAW, CLEAR.
- IDLE: FIFO non-empty → pop head into command register, go LOAD. Else stay.
- LOAD (1 cycle): clear entry → cx=cy=0, go CLEAR. Draw entry → xmin=min(x0,x1), xmax=max, ymin/ymax likewise (unsigned compare); cx=xmin, cy=ymin. If xmin ≥ SCREEN_W or ymin ≥ SCREEN_H → IDLE, no pixels. Else → DRAW.
- DRAW: each cycle pix_x=cx, pix_y=cy, pix_color=1, pix_we=1 (subject to Configuration). Raster x inner, y outer: cx==xmax → cx=xmin, cy++; at cx==xmax && cy==ymax → IDLE.
- CLEAR: same scan over 0..SCREEN_W-1 × 0..SCREEN_H-1, pix_color=0, pix_we=1; after (SCREEN_W-1, SCREEN_H-1) → IDLE with clear_done=1 for the following cycle.
- Pixel count per draw = (xmax-xmin+1)·(ymax-ymin+1); counters N bits, no wrap as N covers screen.
- Commands execute strictly in FIFO order; new commands accepted while drawing.
- Reset mid-operation: abort immediately, FIFO emptied, no further pixel writes.
- Reset values: state IDLE, FIFO empty, pix_x=pix_y=0, pix_color=0, pix_we=0, busy=0, clear_done=0, overflow=0, cmd_ready=0 during reset, 1 on first cycle after.

## Timing
- Command accepted at edge E0 (FSM IDLE, FIFO empty): pop at E1 (enter LOAD), enter DRAW/CLEAR at E2; first pix_we high in cycle after E2, sampled by frame buffer at E3.
- Back-to-back commands: 2 idle cycles (IDLE, LOAD) between last pixel of one and first pixel of next.
- pix_* are registered-state outputs; pix_we never high outside DRAW/CLEAR.
- cmd_ready derived from registered count; reflects a pop only on the next cycle.
- clear_done high exactly one cycle, coincident with IDLE entry; pix_we=0 that cycle.

## Configuration
- SEGRAST_CLIP_EN defined: LOAD clamps xmax to SCREEN_W-1, ymax to SCREEN_H-1; DRAW scans only on-screen pixels, pix_we=1 every DRAW cycle.
- Not defined: no clamping; DRAW scans full rectangle, pix_we=0 on cycles where cx ≥ SCREEN_W or cy ≥ SCREEN_H (pix_x/pix_y still show counters). Off-screen-start rejection in LOAD present in both builds.

## Test plan
- Reset, push (10,20)-(10,22) → pix_we 3 consecutive cycles starting after E2: (10,20),(10,21),(10,22), pix_color=1; then busy=0.
- Push swapped corners (12,5)-(10,4) → 6 pixels in order (10,4),(11,4),(12,4),(10,5),(11,5),(12,5).
- Push clear → 307200 pixel writes color 0 ending at (639,479); clear_done single pulse next cycle; busy high throughout.
- During a clear, push 5 commands → first 4 accepted, cmd_ready=0, 5th dropped, overflow=1 until reset; 4 commands drawn in order after clear.
- Push (630,470)-(700,500): with SEGRAST_CLIP_EN → 100 DRAW cycles, 100 writes; without → 2201 DRAW cycles, 100 with pix_we=1. Push (700,10)-(710,20) → no writes either build.
- Assert reset mid-DRAW → pix_we=0 cycle after edge, FIFO empty, busy=0, queued commands never drawn.
